// File: rtl/ysyx_23060042_lsu.sv
// Load/store unit: one valid/ready bus transaction per instruction, with alignment check,
// response timeout and load extension back to the execute-stage writeback mux.
module ysyx_23060042_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  mren,
    input  logic [1:0]  mwen,
    input  logic        lunsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mrdata,
    output logic        err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, mrdata_q, mrdata_d;
    logic [1:0]  mren_q, mren_d, mwen_q, mwen_d;
    logic        lunsigned_q, lunsigned_d, err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [1:0]  acc_size;
    logic        misaligned;
    logic        is_load_q, is_store_q;
    logic [1:0]  size_q;
    logic [31:0] shifted, load_val;

    // A load request takes precedence when both sizes are non-zero.
    assign acc_size   = (mren != 2'b00) ? mren : mwen;
    assign misaligned = ((acc_size == 2'b10) && addr[0]) ||
                        ((acc_size == 2'b11) && (addr[1:0] != 2'b00));

    assign is_load_q  = (mren_q != 2'b00);
    assign is_store_q = !is_load_q && (mwen_q != 2'b00);
    assign size_q     = is_load_q ? mren_q : mwen_q;

    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = 32'd0;
        if (is_load_q) begin
            case (mren_q)
                2'b01:   load_val = lunsigned_q ? {24'd0, shifted[7:0]}
                                                : {{24{shifted[7]}}, shifted[7:0]};
                2'b10:   load_val = lunsigned_q ? {16'd0, shifted[15:0]}
                                                : {{16{shifted[15]}}, shifted[15:0]};
                default: load_val = shifted;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mren_d      = mren_q;
        mwen_d      = mwen_q;
        lunsigned_d = lunsigned_q;
        mrdata_d    = mrdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d      = addr;
                    wdata_d     = wdata;
                    mren_d      = mren;
                    mwen_d      = mwen;
                    lunsigned_d = lunsigned;
                    mrdata_d    = 32'd0;
                    err_d       = 1'b0;
                    if (acc_size == 2'b00) begin
                        state_d = DONE;
                    end else if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d = 8'd0;
                    if (mem_resp_valid) begin
                        mrdata_d = load_val;
                        state_d  = DONE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A response landing on the timeout cycle still counts as success.
                if (mem_resp_valid) begin
                    mrdata_d = load_val;
                    state_d  = DONE;
                end else if (cnt_d == TMO) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            mren_q      <= 2'b00;
            mwen_q      <= 2'b00;
            lunsigned_q <= 1'b0;
            mrdata_q    <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mren_q      <= mren_d;
            mwen_q      <= mwen_d;
            lunsigned_q <= lunsigned_d;
            mrdata_q    <= mrdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign mem_req_valid = (state_q == REQ);
    assign mrdata        = mrdata_q;
    assign err           = err_q;
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wen       = is_store_q;
    assign mem_wdata     = wdata_q << {addr_q[1:0], 3'b000};

    always_comb begin
        mem_wmask = 4'b0000;
        if (is_store_q) begin
            case (size_q)
                2'b01:   mem_wmask = 4'b0001 << addr_q[1:0];
                2'b10:   mem_wmask = 4'b0011 << addr_q[1:0];
                default: mem_wmask = 4'b1111;
            endcase
        end
    end
endmodule

// File: doc/ysyx_23060042_lsu.md
Name: ysyx_23060042_lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Takes the ALU-computed effective address, the store data (rdata2) and the access control.
- Performs one multi-cycle transaction on a valid/ready memory bus.
- Returns the extended load value as mrdata to the execute-stage writeback mux. Non-memory instructions pass through in one cycle.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_resp_valid before flagging an error; range 1..255.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  LSU can accept an instruction
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rdata2)
- mren  in  2  load size: 00 none, 01 byte, 10 half, 11 word
- mwen  in  2  store size, same encoding
- lunsigned  in  1  1 = zero-extend load, 0 = sign-extend
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts result
- mrdata  out  32  extended load data; 0 for non-loads
- err  out  1  misaligned or timed-out access; qualified by out_valid
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wen  out  1  1 = write
- mem_wdata  out  32  store data shifted to byte lane
- mem_wmask  out  4  byte strobes
- mem_resp_valid  in  1  response valid (1-cycle pulse)
- mem_rdata  in  32  read word

Behaviour:
- Reset (rst=0, async): state=IDLE; in_ready=1; out_valid=0; mem_req_valid=0; mrdata=0; err=0; timeout counter=0. All captured registers are cleared.
- In IDLE, in_ready=1. Accept occurs on in_valid & in_ready. On accept, latch addr, wdata, mren, mwen and lunsigned.
- Accept with mren=00 and mwen=00: go to DONE next cycle. mrdata=0, err=0.
- Accept with mren!=00 and mwen!=00 is illegal. Treat it as a load; the store is ignored.
- Misalignment is checked at accept: half with addr[0]=1, or word with addr[1:0]!=00. A misaligned access goes to DONE with err=1 and mrdata=0. No bus request is issued.
- Aligned access goes to REQ. mem_req_valid=1 with mem_addr, mem_wen, mem_wdata and mem_wmask held stable until mem_req_ready.
- mem_wmask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- mem_wdata = wdata<<(8*addr[1:0]). Loads drive mem_wmask=0.
- REQ with mem_req_ready=1 goes to WAIT. The counter is cleared to 0 and mem_req_valid drops the next cycle.
- WAIT increments the counter each cycle.
  - mem_resp_valid=1: capture data and go to DONE.
  - Counter reaching TIMEOUT with no response: go to DONE with err=1, mrdata=0.
  - mem_resp_valid in the same cycle as the counter reaching TIMEOUT: the response wins, err=0.
- A response pulse arriving in REQ, the same cycle as mem_req_ready: accept it as the response and go straight to DONE, skipping WAIT. mem_resp_valid in IDLE or DONE is ignored.
- Load extraction: shift mem_rdata right by 8*addr[1:0], take 8/16/32 bits, then zero- or sign-extend per lunsigned. Stores give mrdata=0.
- DONE: out_valid=1 and mrdata/err are held stable until out_ready.
  - out_ready in DONE: go to IDLE, out_valid=0 the next cycle.
  - in_ready=0 in REQ, WAIT and DONE, so there is no accept-during-handshake.
- Latency with out_ready tied high:
  - non-memory: 1 cycle accept→out_valid;
  - memory with zero-wait bus (ready and response in the REQ cycle): 2 cycles;
  - each bus wait state adds 1 cycle.
- Reset asserted mid-transaction aborts immediately: outputs go to their reset values and no response is consumed afterwards.

Test Plan:
- Reset: hold rst=0 with random inputs → in_ready=1, out_valid=0, mem_req_valid=0, mrdata=0; release rst → remains idle.
- Load byte signed: addr=0x80000003, mren=01, lunsigned=0, mem_rdata=0x80FF1234, zero-wait bus → mem_addr=0x80000000, mrdata=0xFFFFFF80, err=0, out_valid 2 cycles after accept.
- Store half: addr=0x80000002, mwen=10, wdata=0x0000ABCD, mem_req_ready delayed 3 cycles → mem_wmask=4'b1100, mem_wdata=0xABCD0000 stable throughout REQ, mrdata=0 at DONE.
- Misaligned word load: addr=0x80000001, mren=11 → no mem_req_valid ever, out_valid=1 next cycle with err=1.
- Timeout: TIMEOUT=4, load accepted, mem_resp_valid never asserted → err=1 exactly 4 cycles after entering WAIT; separately, response on the 4th cycle → err=0 with valid data.
- Backpressure and abort: out_ready=0 for 5 cycles → out_valid/mrdata stable, in_ready=0. Then rst=0 pulse in WAIT → immediate idle, and a later mem_resp_valid does not produce out_valid.
